mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit; next generation of the datapath ALU.
- Adds MULT/MULTU/DIV/DIVU with HI/LO result registers and MTHI/MTLO writes.
- Sits beside the ALU in the datapath; the controller stalls on busy and reads hi/lo after the done pulse.
- Computes one bit per cycle: shift-add multiply, restoring divide, sign fix-up in a final cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal range WIDTH >= 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when busy=0.
- op  in  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- mthi  in  1  write wd into hi.
- mtlo  in  1  write wd into lo.
- wd  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- hi  out  WIDTH  multiply: upper product; divide: remainder.
- lo  out  WIDTH  multiply: lower product; divide: quotient.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter 0.
- Reset mid-operation aborts the operation immediately; no done pulse; hi/lo=0.
- IDLE:
  - start=1 at edge E0 latches op, |a| and |b|, and the result-sign flags.
  - For signed ops, the magnitude is the two's-complement absolute value; the sign flags are 0 for unsigned ops.
  - Transition to RUN; busy=1 from E0.
- RUN: one iteration per edge for exactly WIDTH edges (E1..E_WIDTH). The counter is $clog2(WIDTH+1) bits wide. Then go to FIX.
  - Multiply: 2*WIDTH-bit accumulator, shift-add, unsigned on magnitudes.
  - Divide: restoring algorithm on magnitudes; WIDTH+1-bit partial remainder.
- FIX (edge E_WIDTH+1):
  - Apply sign correction.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
    - Quotient truncates toward zero.
  - Write hi/lo, set done=1, busy=0, return to IDLE.
- Latency: start-to-done is WIDTH+1 edges.
  - done is high for exactly the one cycle after E_WIDTH+1.
  - busy is low in that same cycle.
- Back-to-back: start=1 in the done cycle is accepted; the next operation begins.
- start while busy=1: ignored; no queueing.
- a, b, op: captured at start. Changes during busy have no effect.
- hi/lo hold their old values throughout busy. They change only at FIX, on mthi/mtlo, or on reset.
- mthi/mtlo:
  - Take effect at the next edge only when busy=0.
  - Ignored when busy=1.
  - Both may be asserted together; both registers are written.
  - If mthi/mtlo coincide with an accepted start, the write occurs, then is overwritten at FIX.
  - In the done cycle, mthi/mtlo take effect and override the just-written result.
- Divide by zero (b=0), both DIVU and DIV:
  - lo = all ones.
  - hi = a (original dividend, unmodified).
  - Normal latency; no exception flag.
- Signed overflow, DIV of MIN by -1: lo=MIN, hi=0. This falls out of the magnitude algorithm with no special case.
- Multiply never overflows; the full 2*WIDTH product is always delivered.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at E0 -> busy 1 for 33 cycles; done pulses once in the cycle after E33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=7 b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Corner cases:
  - DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - start asserted in the done cycle -> second result after a further 33 edges.
- Idle writes and ignored inputs:
  - Idle: mthi wd=0xDEAD00AD -> hi=0xDEAD00AD next cycle.
  - mtlo wd=0xBEEF -> lo=0xBEEF; hi unchanged.
  - During busy: mthi, a second start, and changes to a/b are all ignored; the result matches the original operands.
- Reset mid-operation: start MULTU 3×4, assert reset at cycle 10 of busy -> busy=0 and hi=lo=0 immediately. No done pulse for 40 cycles after release. A fresh MULTU 3×4 -> lo=12, hi=0.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter - iterative multiply/divide unit with HI/LO result registers.
//
// Computes one result bit per clock: shift-add multiply or restoring
// divide, both on operand magnitudes. A final cycle applies the sign
// correction and writes HI/LO.
//
// Ports:
//   clk    in   1      clock, rising-edge
//   reset  in   1      asynchronous active-high reset
//   start  in   1      begin an operation (sampled only while idle)
//   op     in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in   WIDTH  multiplicand / dividend (rs)
//   b      in   WIDTH  multiplier / divisor (rt)
//   mthi   in   1      write wd into hi (idle only)
//   mtlo   in   1      write wd into lo (idle only)
//   wd     in   WIDTH  data for mthi/mtlo
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse when hi/lo hold a new result
//   hi     out  WIDTH  product upper half / remainder
//   lo     out  WIDTH  product lower half / quotient
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes; sign flags are forced to 0 for unsigned ops.
  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag;
  assign aNeg = op[0] & a[WIDTH-1];
  assign bNeg = op[0] & b[WIDTH-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;

  // Multiply step: the low half of acc holds the remaining multiplier
  // bits, the high half the running partial product.
  logic [WIDTH:0]     mulSum;
  assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Divide step: the WIDTH+1-bit partial remainder is the stored
  // remainder shifted left with the next dividend bit. Once a trial
  // subtraction succeeds the difference is below the divisor, so a
  // WIDTH-bit difference is exact.
  logic [WIDTH:0]     shifted;
  logic               geq;
  logic [WIDTH-1:0]   diff;
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign geq     = shifted >= {1'b0, opnd_q};
  assign diff    = shifted[WIDTH-1:0] - opnd_q;

  // Sign fix-up. Divide by zero naturally leaves remainder = |a|, which
  // the dividend-sign correction turns back into a; only the quotient
  // needs forcing to all ones.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remFix;
  assign prod   = negRes_q ? -acc_q : acc_q;
  assign quot   = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFix = negRem_q ? -rem_q : rem_q;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      isDiv_q  <= isDiv_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: capture at start, iterate WIDTH times, then fix up.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    isDiv_d  = isDiv_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // Direct writes are honoured whenever idle, including the done cycle
    // and alongside an accepted start.
    if (state_q == IDLE) begin
      if (mthi) hi_d = wd;
      if (mtlo) lo_d = wd;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          isDiv_d  = op[1];
          negRes_d = aNeg ^ bNeg;
          negRem_d = aNeg;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? aMag : bMag)};
          opnd_d   = op[1] ? bMag : aMag;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (isDiv_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], geq};
          rem_d = geq ? diff : shifted[WIDTH-1:0];
        end else begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quot;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter - directed testbench for mdu_iter (WIDTH=32) with
// hand-computed expected results.
module tb_mdu_iter;

   localparam logic [1:0] MULTU = 2'b00;
   localparam logic [1:0] MULT  = 2'b01;
   localparam logic [1:0] DIVU  = 2'b10;
   localparam logic [1:0] DIV   = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b, wd;
   logic        mthi, mtlo;
   logic        busy, done;
   logic [31:0] hi, lo;

   int vecCount  = 0;
   int missCount = 0;

   mdu_iter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wd(wd),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // 10-time-unit clock; rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; raises start for one edge and returns at
   // the falling edge of the first busy cycle.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] aa,
                                input logic [31:0] bb);
      op = o; a = aa; b = bb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts remaining busy cycles up to the done pulse (bounded), then
   // checks the cycle count and the result registers.
   task automatic finishOp(input string tag, input int expCycles,
                           input logic [31:0] expHi, input logic [31:0] expLo);
      int cycles = 0;
      int guard  = 0;
      while (done !== 1'b1 && guard < 200) begin
         if (busy === 1'b1) cycles++;
         guard++;
         @(negedge clk);
      end
      checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
      checkOutput({tag, " busy cycles"}, cycles, expCycles);
      checkOutput({tag, " busy in done cycle"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, " hi"}, hi, expHi);
      checkOutput({tag, " lo"}, lo, expLo);
   endtask

   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] expHi,
                        input logic [31:0] expLo);
      @(negedge clk);
      applyStimulus(o, aa, bb);
      finishOp(tag, 33, expHi, expLo);
   endtask

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneSeen;
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wd = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      reset = 1'b0;

      // Main function with latency check on every operation.
      runOp("MULTU max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      @(negedge clk);
      checkOutput("done width", {31'b0, done}, 32'd0);
      runOp("MULT -3x5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      runOp("MULT min^2", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      runOp("DIV -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("DIVU 7/2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
      runOp("DIV 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

      // Corner cases.
      runOp("DIVU by 0", DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
      runOp("DIV -7 by 0", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      runOp("DIV min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

      // Back-to-back: start issued in the done cycle of the previous op.
      runOp("b2b first", MULTU, 32'd100, 32'd200, 32'd0, 32'd20000);
      applyStimulus(DIVU, 32'd100, 32'd7);
      finishOp("b2b second", 33, 32'd2, 32'd14);

      // Idle register writes.
      @(negedge clk);
      mthi = 1'b1; wd = 32'hDEAD00AD;
      @(negedge clk);
      mthi = 1'b0;
      checkOutput("mthi hi", hi, 32'hDEAD00AD);
      checkOutput("mthi lo kept", lo, 32'd14);
      mtlo = 1'b1; wd = 32'h0000BEEF;
      @(negedge clk);
      mtlo = 1'b0;
      checkOutput("mtlo lo", lo, 32'h0000BEEF);
      checkOutput("mtlo hi kept", hi, 32'hDEAD00AD);

      // Inputs ignored while busy; hi/lo hold their previous values.
      @(negedge clk);
      applyStimulus(MULTU, 32'd6, 32'd7);
      mthi = 1'b1; mtlo = 1'b1; wd = 32'h11111111;
      start = 1'b1; op = DIV; a = 32'h55; b = 32'd3;
      repeat (3) @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
      checkOutput("busy hold hi", hi, 32'hDEAD00AD);
      checkOutput("busy hold lo", lo, 32'h0000BEEF);
      finishOp("ignored inputs", 30, 32'd0, 32'd42);
      @(negedge clk);
      checkOutput("no queued op", {31'b0, busy}, 32'd0);

      // Leave a nonzero hi so the reset clearing is observable.
      runOp("DIVU 9/4", DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

      // Reset during an operation.
      @(negedge clk);
      applyStimulus(MULTU, 32'd3, 32'd4);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort busy", {31'b0, busy}, 32'd0);
      checkOutput("abort hi", hi, 32'd0);
      checkOutput("abort lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("no done after abort", doneSeen, 32'd0);
      runOp("MULTU 3x4", MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
